// File: rtl/clock_strobe_gen.sv
// Multi-channel programmable clock divider with registered rise/fall strobes,
// plus a synchronised edge detector for one asynchronous external input.
module clock_strobe_gen #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [CHANNELS-1:0]           enable,
  input  logic [CHANNELS*DIV_WIDTH-1:0] div_half,
  output logic [CHANNELS-1:0]           clk_out,
  output logic [CHANNELS-1:0]           rise_pulse,
  output logic [CHANNELS-1:0]           fall_pulse,
  input  logic                          ext_in,
  output logic                          ext_level,
  output logic                          ext_rise,
  output logic                          ext_fall
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } ch_state_e;

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    ch_state_e            state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] div_in;
    logic                 clk_q, clk_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;

    assign div_in = div_half[i*DIV_WIDTH +: DIV_WIDTH];

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        div_q   <= '0;
        clk_q   <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        div_q   <= div_d;
        clk_q   <= clk_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    // Next-state: a disable while high detours through STOPPING to drive the low edge.
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        ST_IDLE:     if (enable[i]) state_d = ST_RUN;
        ST_RUN:      if (!enable[i]) state_d = clk_q ? ST_STOPPING : ST_IDLE;
        ST_STOPPING: state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end

    // Datapath and strobes; the first enabled cycle already counts as count 0.
    always_comb begin
      cnt_d  = '0;
      div_d  = div_q;
      clk_d  = clk_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          div_d = div_in;
          clk_d = 1'b0;
          if (enable[i]) begin
            if (div_in == '0) begin
              clk_d  = 1'b1;
              rise_d = 1'b1;
            end else begin
              cnt_d = DIV_WIDTH'(1);
            end
          end
        end
        ST_RUN: begin
          if (!enable[i]) begin
            clk_d  = 1'b0;
            fall_d = clk_q;
            div_d  = div_in;
          end else if (cnt_q == div_q) begin
            clk_d  = ~clk_q;
            rise_d = ~clk_q;
            fall_d = clk_q;
            div_d  = div_in;
          end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
          end
        end
        ST_STOPPING: begin
          clk_d = 1'b0;
          div_d = div_in;
        end
        default: begin
          clk_d = 1'b0;
          div_d = div_in;
        end
      endcase
    end

    assign clk_out[i]    = clk_q;
    assign rise_pulse[i] = rise_q;
    assign fall_pulse[i] = fall_q;
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   erise_q, erise_d;
  logic                   efall_q, efall_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      erise_q <= 1'b0;
      efall_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      erise_q <= erise_d;
      efall_q <= efall_d;
    end
  end

  // Synchroniser shift chain followed by a registered edge compare.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], ext_in};
    prev_d  = sync_q[SYNC_STAGES-1];
    erise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    efall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

  assign ext_level = sync_q[SYNC_STAGES-1];
  assign ext_rise  = erise_q;
  assign ext_fall  = efall_q;

endmodule

// File: doc/clock_strobe_gen.md
Name: clock_strobe_gen

Overview:
- Parametrised, multi-channel successor to the panel-timing divider, generator and edge-detect helpers.
- Generates CHANNELS independent divided clocks from the single system clock, each with a runtime-programmable half-period.
- Each channel also emits one-cycle rise/fall strobes, so downstream e-paper sequencing logic can run on the system clock instead of the derived clocks.
- Also provides a synchronised, registered edge detector for one asynchronous external input, such as the panel busy line.

Parameters:
- CHANNELS, 2, number of independent divider channels (1..8).
- DIV_WIDTH, 16, width of each half-period count field.
- SYNC_STAGES, 2, synchroniser depth for ext_in (2..4).

Ports:
- clock  in  1  system clock; everything is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  CHANNELS  per-channel run enable.
- div_half  in  CHANNELS*DIV_WIDTH  per-channel half-period minus 1; channel i occupies bits [i*DIV_WIDTH +: DIV_WIDTH].
- clk_out  out  CHANNELS  divided clock outputs, registered.
- rise_pulse  out  CHANNELS  one-clock strobe in the cycle clk_out[i] becomes 1.
- fall_pulse  out  CHANNELS  one-clock strobe in the cycle clk_out[i] becomes 0.
- ext_in  in  1  asynchronous external input.
- ext_level  out  1  synchronised ext_in.
- ext_rise  out  1  one-clock strobe on a synchronised 0->1 transition of ext_in.
- ext_fall  out  1  one-clock strobe on a synchronised 1->0 transition of ext_in.

Behaviour:
- Reset (asynchronous assert, synchronous-edge release):
  - all counters, active divide registers, clk_out, rise_pulse, fall_pulse, synchroniser flops, ext_level, ext_rise and ext_fall go to 0.
  - Reset mid-period aborts the period immediately; no strobe is produced on reset.
- Per-channel state: counter[DIV_WIDTH], active_div[DIV_WIDTH], clk_out bit. The three channel states are IDLE, RUN and STOPPING.
- IDLE (enable=0, clk_out=0):
  - counter holds 0.
  - active_div is loaded from div_half every cycle.
  - No strobes.
- IDLE->RUN on a cycle with enable=1. Counting starts from 0 with clk_out=0.
- RUN:
  - If counter==active_div: counter<=0, clk_out toggles, and the matching strobe is asserted in the same cycle clk_out changes.
  - Otherwise counter increments by 1.
  - active_div reloads from div_half only on the terminal-count cycle, so a mid-period change of div_half takes effect at the next half-period boundary. No glitch or short half-period results.
  - Half-period = active_div+1 clocks; period = 2*(active_div+1).
  - div_half=0 gives clock/2, with clk_out toggling every cycle and alternating rise/fall strobes.
  - Maximum value gives period 2^(DIV_WIDTH+1). The counter never wraps past active_div.
- RUN->IDLE when enable=0 with clk_out=0: counter cleared the next cycle, no strobe.
- RUN->STOPPING when enable=0 with clk_out=1:
  - On the next clock, clk_out<=0, fall_pulse asserted for one cycle, counter<=0.
  - The channel is then IDLE. Disable never leaves clk_out stuck high.
- enable re-asserted during STOPPING is ignored for that cycle. The channel restarts from IDLE on the next cycle in which enable=1.
- First rise after enable: clk_out rises at the end of the (active_div+1)-th enabled cycle, i.e. on the (div_half+1)-th clock edge after enable is sampled high.
- Strobes are registered, exactly one clock wide, and never simultaneous within a channel. Channels are fully independent; simultaneous terminal counts on different channels are all honoured.
- External edge path:
  - ext_in passes through a SYNC_STAGES flop chain; the last stage drives ext_level.
  - A further registered compare produces ext_rise = ext_level & ~prev and ext_fall = ~ext_level & prev, both registered.
  - Latency: ext_level goes high SYNC_STAGES edges after the first edge sampling ext_in=1; ext_rise goes high one edge later and lasts one cycle.
  - Pulses of ext_in shorter than one clock may be missed. This is permitted.

Test Plan:
- Reset held 5 cycles with enable=all 1 -> every output is 0; after release, the first rise of ch0 (div_half=3) comes 4 edges later, and the steady period is 8 clocks with 50% duty.
- ch0 div_half=0, ch1 div_half=5, both enabled -> ch0 toggles every clock; ch1 period is 12; rise/fall strobes are one clock wide and coincide with the clk_out transitions.
- ch0 running at div_half=3; change to 1 at counter=1 of a high phase -> that high phase stays 4 clocks, and all subsequent half-periods are 2 clocks.
- Drop enable while clk_out=1 -> clk_out=0 and fall_pulse=1 on the next edge, then no activity; drop enable while clk_out=0 -> no strobe.
- SYNC_STAGES=2; ext_in goes 0->1 between edges, then 1->0 after 10 clocks -> ext_level high at edge 2, ext_rise high for edge 3 only, and ext_fall a single pulse 10 clocks later.
- Assert reset_n low asynchronously mid-half-period with ch0 clk_out=1 -> clk_out drops immediately with no fall_pulse, and counting restarts from 0 after release.
